// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters that stall issue on RAW hazards
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ADDR_W-1:0]   id_src1,
    input  logic [ADDR_W-1:0]   id_src2,
    input  logic                id_use_src1,
    input  logic                id_use_src2,
    input  logic [ADDR_W-1:0]   id_dest,
    input  logic                id_wb_en,
    output logic                id_ready,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    eff [NUM_REGS];
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] inc;
    logic                hazard;
    logic                sat;
    logic                uf_d;
    logic                uf_q;

    // Same-cycle write-back bypasses into the hazard check; flush zeroes all counts.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec[r] = wb_en && wb_dest == ADDR_W'(r) && cnt_q[r] != '0;
            eff[r] = cnt_q[r] - CNT_W'(dec[r]);
        end
        hazard = (id_use_src1 && eff[id_src1] != '0) || (id_use_src2 && eff[id_src2] != '0);
        sat = id_wb_en && eff[id_dest] == CNT_MAX;
        id_ready = !rst && !flush && !hazard && !sat;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r] = id_valid && id_ready && id_wb_en && id_dest == ADDR_W'(r);
            cnt_d[r] = flush ? '0 : cnt_q[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
            busy_vec[r] = cnt_q[r] != '0;
        end
        uf_d = uf_q || (wb_en && !flush && cnt_q[wb_dest] == '0);
    end

    // Counter and sticky underflow state, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            uf_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            uf_q <= uf_d;
        end
    end

    assign wb_underflow = uf_q;
endmodule
